// File: rtl/mmio_out_port_if.sv
// Bus bundle for mmio_out_port: the processor data-memory access signals
// plus the valid/ready stream that drains the output FIFO.
interface mmio_out_port_if;
  logic [25:0] addr;
  logic        read;
  logic        write;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        hit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  // Processor + consumer side.
  modport master (
    output addr, read, write, data_in, out_ready,
    input  data_out, hit, out_data, out_valid
  );

  // Register window side.
  modport slave (
    input  addr, read, write, data_in, out_ready,
    output data_out, hit, out_data, out_valid
  );
endinterface

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: a four-register window (TX, STATUS, CYCLE,
// CTRL) on the processor data bus. Words written to TX are queued in a FIFO
// and drained over a valid/ready stream.
module mmio_out_port #(
  parameter logic [25:0] BASE_ADDR  = 26'h3FFFFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  mmio_out_port_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    REG_TX     = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  // Access decode
  logic  sel;
  reg_e  offset;
  logic  rd_acc, wr_acc, ill_acc;
  logic  wr_d, wr_fire;

  assign sel     = (bus.addr[25:2] == BASE_ADDR[25:2]);
  assign offset  = reg_e'(bus.addr[1:0]);
  assign rd_acc  = sel &  bus.read & ~bus.write;
  assign wr_acc  = sel & ~bus.read &  bus.write;
  assign ill_acc = sel &  bus.read &  bus.write;
  // A held WRITE fires only on its first cycle.
  assign wr_fire = wr_acc & ~wr_d;

  logic push_req, flush, clr_ovf, clr_ill, cycle_load;
  assign push_req   = wr_fire && (offset == REG_TX);
  assign cycle_load = wr_fire && (offset == REG_CYCLE);
  assign flush      = wr_fire && (offset == REG_CTRL) && bus.data_in[2];
  assign clr_ovf    = wr_fire && (offset == REG_CTRL) && bus.data_in[0];
  assign clr_ill    = wr_fire && (offset == REG_CTRL) && bus.data_in[1];

  // FIFO state
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_ok, drop;
  logic          ovf, ill;
  logic [31:0]   cycle;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = bus.out_valid & bus.out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'd0 : mem[rd_ptr];

  // FIFO storage write port
  // NOTE: the storage array has no reset; validity is tracked by count and
  // pointers, so resetting the data itself would only add logic.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers, occupancy and sticky flags
  // NOTE: all sequential state uses non-blocking assignments so every
  // register sees pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ill    <= 1'b0;
      wr_d   <= 1'b0;
    end else begin
      wr_d <= wr_acc;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)      count <= count + CW'(1);
        else if (!push_ok && pop) count <= count - CW'(1);
      end
      if (clr_ovf)           ovf <= 1'b0;
      else if (drop && !flush) ovf <= 1'b1;
      if (clr_ill)      ill <= 1'b0;
      else if (ill_acc) ill <= 1'b1;
    end
  end

  // Free-running cycle counter; a load also takes this cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle <= 32'd0;
    else        cycle <= (cycle_load ? bus.data_in : cycle) + 32'd1;
  end

  // Read mux over pre-edge register state
  logic [31:0] rd_data;
  // NOTE: rd_data gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = 32'd0;
    case (offset)
      REG_STATUS: rd_data = {16'd0, 8'(count), 4'd0, ill, ovf, full, empty};
      REG_CYCLE:  rd_data = cycle;
      default:    rd_data = 32'd0;
    endcase
  end

  // Registered read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= 32'd0;
      bus.hit      <= 1'b0;
    end else begin
      bus.data_out <= rd_acc ? rd_data : 32'd0;
      bus.hit      <= rd_acc;
    end
  end

endmodule
